// File: rtl/sseg_pkg.sv
// Purpose: shared constants for the seven-segment scan controller (segment table, off codes, register map).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sseg_pkg;

    // Both anode and cathode lines are active-low, so "off" means all ones.
    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [7:0] CATH_OFF  = 8'hFF;

    // MMIO register map.
    typedef enum logic [1:0] {
        ADDR_VALUE  = 2'd0,
        ADDR_MASK   = 2'd1,
        ADDR_BRIGHT = 2'd2,
        ADDR_RSVD   = 2'd3
    } reg_addr_e;

    // Segment patterns {a,b,c,d,e,f,g}, active-low, indexed by hex nibble.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0001100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Active-low one-hot anode select for a digit index.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// Purpose: hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (4-bit hex digit in), seg (7-bit {a..g} active-low out).
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Purpose: MMIO-programmed 4-digit seven-segment scanner with PWM dimming and frame-synchronous register update.
// Latency: register writes reach the display at the next frame boundary; pins lag internal scan state by 1 cycle.
// Backpressure: none; writes are always accepted (addr 3 ignored).
// Ports: CLK/RST (sync, active-high); WR_EN/WR_ADDR/WR_DATA register write port;
//        CATHODES {dp,a..g} and ANODES {d4..d1} active-low pins; FRAME_START pulse; DIGIT_IDX scan position.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int CLK_DIV  = 100000,
    parameter int PWM_BITS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_EN,
    input  logic [1:0]  WR_ADDR,
    input  logic [15:0] WR_DATA,
    output logic [7:0]  CATHODES,
    output logic [3:0]  ANODES,
    output logic        FRAME_START,
    output logic [1:0]  DIGIT_IDX
);

    localparam int                  SLOT_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [SLOT_W-1:0]   SLOT_LAST   = SLOT_W'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_FULL = '1;

    // Shadow set: written by the CPU at any time.
    logic [15:0]         sh_value;
    logic [3:0]          sh_en;
    logic [3:0]          sh_dp;
    logic [PWM_BITS-1:0] sh_bright;

    // Active set: what the scanner displays; only reloaded at frame boundaries.
    logic [15:0]         act_value;
    logic [3:0]          act_en;
    logic [3:0]          act_dp;
    logic [PWM_BITS-1:0] act_bright;

    logic [SLOT_W-1:0]   slot_cnt;
    logic [1:0]          digit_idx;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic                slot_end;
    logic                frame_end;

    logic [3:0]          nibble;
    logic                en_bit;
    logic                dp_bit;
    logic                bright_ok;
    logic [6:0]          seg;
    logic [3:0]          an_next;
    logic [7:0]          cath_next;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (digit_idx == 2'd3);

    // ---------------- shadow register writes ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_value  <= 16'h0000;
            sh_en     <= 4'hF;
            sh_dp     <= 4'h0;
            sh_bright <= BRIGHT_FULL;
        end else if (WR_EN) begin
            case (reg_addr_e'(WR_ADDR))
                ADDR_VALUE:  sh_value <= WR_DATA;
                ADDR_MASK: begin
                    sh_en <= WR_DATA[3:0];
                    sh_dp <= WR_DATA[7:4];
                end
                ADDR_BRIGHT: sh_bright <= WR_DATA[PWM_BITS-1:0];
                default: ;
            endcase
        end
    end

    // ---------------- scan counters and frame-synchronous reload ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt   <= '0;
            digit_idx  <= 2'd0;
            pwm_cnt    <= '0;
            act_value  <= 16'h0000;
            act_en     <= 4'hF;
            act_dp     <= 4'h0;
            act_bright <= BRIGHT_FULL;
        end else begin
            // PWM phase runs freely across slots so dimming has no per-digit phase reset.
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (slot_end) begin
                slot_cnt  <= '0;
                // Wraps 3 -> 0 at the frame boundary.
                digit_idx <= digit_idx + 2'd1;
            end else begin
                slot_cnt  <= slot_cnt + SLOT_W'(1);
            end
            // The shadow value captured here excludes a write landing on this same edge,
            // so such a write shows one frame later.
            if (frame_end) begin
                act_value  <= sh_value;
                act_en     <= sh_en;
                act_dp     <= sh_dp;
                act_bright <= sh_bright;
            end
        end
    end

    // ---------------- digit select and output decode ----------------
    sseg_decode u_decode (
        .nibble (nibble),
        .seg    (seg)
    );

    assign bright_ok = (act_bright == BRIGHT_FULL) || (pwm_cnt < act_bright);

    always_comb begin
        nibble    = 4'h0;
        en_bit    = 1'b0;
        dp_bit    = 1'b0;
        an_next   = ANODE_OFF;
        cath_next = CATH_OFF;
        // An undecodable index leaves en_bit low, which blanks the display.
        case (digit_idx)
            2'd0: begin nibble = act_value[3:0];   en_bit = act_en[0]; dp_bit = act_dp[0]; end
            2'd1: begin nibble = act_value[7:4];   en_bit = act_en[1]; dp_bit = act_dp[1]; end
            2'd2: begin nibble = act_value[11:8];  en_bit = act_en[2]; dp_bit = act_dp[2]; end
            2'd3: begin nibble = act_value[15:12]; en_bit = act_en[3]; dp_bit = act_dp[3]; end
            default: ;
        endcase
        if (en_bit && bright_ok) begin
            an_next   = anode_sel(digit_idx);
            cath_next = {~dp_bit, seg};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ANODES   <= ANODE_OFF;
            CATHODES <= CATH_OFF;
        end else begin
            ANODES   <= an_next;
            CATHODES <= cath_next;
        end
    end

    // The first cycle after reset release already sits at slot 0 of digit 0,
    // so this naturally marks that cycle as a frame start too.
    assign FRAME_START = ~RST && (slot_cnt == '0) && (digit_idx == 2'd0);
    assign DIGIT_IDX   = digit_idx;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [15:0] wr_data = 16'h0000;

    logic [7:0]  cath4, cath16;
    logic [3:0]  an4, an16;
    logic        fs4, fs16;
    logic [1:0]  idx4, idx16;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.CLK_DIV(4), .PWM_BITS(4)) u_dut4 (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .CATHODES(cath4), .ANODES(an4), .FRAME_START(fs4), .DIGIT_IDX(idx4)
    );

    sseg_scan_ctrl #(.CLK_DIV(16), .PWM_BITS(4)) u_dut16 (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .CATHODES(cath16), .ANODES(an16), .FRAME_START(fs16), .DIGIT_IDX(idx16)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n = cycles elapsed since the last reset edge: digit = (n/D)%4, pwm phase = n%16,
    // a frame is 4*D cycles and the displayed set changes only where n crosses a frame multiple.
    int          dv [2] = '{4, 16};
    int          n;
    bit          model_valid = 1'b0;
    logic [15:0] sh_val;
    logic [3:0]  sh_en, sh_dp, sh_br;
    logic [15:0] ac_val [2];
    logic [3:0]  ac_en [2];
    logic [3:0]  ac_dp [2];
    logic [3:0]  ac_br [2];
    logic [3:0]  exp_an [2];
    logic [7:0]  exp_ca [2];

    function automatic logic [6:0] seg_ref(input int v);
        case (v)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0001100;
            10: return 7'b0001000; 11: return 7'b1100000;
            12: return 7'b0110001; 13: return 7'b1000010;
            14: return 7'b0110000; default: return 7'b0111000;
        endcase
    endfunction

    task automatic advance(input logic r, input logic we, input logic [1:0] a, input logic [15:0] d);
        if (r) begin
            n = 0;
            sh_val = 16'h0; sh_en = 4'hF; sh_dp = 4'h0; sh_br = 4'hF;
            for (int i = 0; i < 2; i++) begin
                ac_val[i] = 16'h0; ac_en[i] = 4'hF; ac_dp[i] = 4'h0; ac_br[i] = 4'hF;
                exp_an[i] = 4'hF; exp_ca[i] = 8'hFF;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int  dig, pwm, nib;
                bit  lit;
                dig = (n / dv[i]) % 4;
                pwm = n % 16;
                nib = int'((ac_val[i] >> (4 * dig)) & 16'hF);
                lit = ac_en[i][dig] && (ac_br[i] == 4'hF || pwm < int'(ac_br[i]));
                exp_an[i] = lit ? 4'(~(1 << dig)) : 4'hF;
                exp_ca[i] = lit ? {~ac_dp[i][dig], seg_ref(nib)} : 8'hFF;
                if (n % (4 * dv[i]) == 4 * dv[i] - 1) begin
                    ac_val[i] = sh_val; ac_en[i] = sh_en; ac_dp[i] = sh_dp; ac_br[i] = sh_br;
                end
            end
            n++;
            if (we) begin
                if (a == 2'd0) sh_val = d;
                else if (a == 2'd1) begin sh_en = d[3:0]; sh_dp = d[7:4]; end
                else if (a == 2'd2) sh_br = d[3:0];
            end
        end
    endtask

    // One clock cycle: check registered pins, drive new inputs, check the
    // input-dependent outputs for the state now in effect, then advance the model.
    task automatic tick(input logic r, input logic we, input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        if (model_valid) begin
            chk("an4",   16'(an4),    16'(exp_an[0]));
            chk("cath4", 16'(cath4),  16'(exp_ca[0]));
            chk("an16",  16'(an16),   16'(exp_an[1]));
            chk("cath16",16'(cath16), 16'(exp_ca[1]));
        end
        rst = r; wr_en = we; wr_addr = a; wr_data = d;
        #1;
        if (model_valid) begin
            chk("fs4",   16'(fs4),   16'(!r && (n % 16 == 0)));
            chk("fs16",  16'(fs16),  16'(!r && (n % 64 == 0)));
            chk("idx4",  16'(idx4),  16'((n / 4) % 4));
            chk("idx16", 16'(idx16), 16'((n / 16) % 4));
        end
        advance(r, we, a, d);
        model_valid = 1'b1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) tick(1'b0, 1'b0, 2'd0, 16'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        tick(1'b0, 1'b1, a, d);
    endtask

    // Lit-cycle count of the CLK_DIV=16 instance over one of its frames,
    // started once a newly written brightness is certainly active.
    task automatic lit_frame16(input logic [3:0] br, input int exp_lit, input string tag);
        int lit;
        wr(2'd2, {12'h0, br});
        idle(1);
        while (n % 64 != 1) idle(1);
        lit = 0;
        repeat (64) begin
            idle(1);
            if (an16 != 4'hF) lit++;
        end
        chk(tag, 16'(lit), 16'(exp_lit));
    endtask

    initial begin
        // reset hold
        repeat (3) tick(1'b1, 1'b0, 2'd0, 16'h0);
        chk("rst_an", 16'(an4), 16'hF);
        chk("rst_ca", 16'(cath4), 16'hFF);
        idle(5);

        // value write mid-frame, becomes visible on the next frame
        wr(2'd0, 16'h1A3F);
        idle(40);

        // mask: EN=0101, DP=0011
        wr(2'd1, 16'h0035);
        idle(40);

        // brightness duty per frame (64 cycles, all digits enabled)
        wr(2'd1, 16'h000F);
        lit_frame16(4'd0,  0,  "lit_br0");
        lit_frame16(4'd4,  16, "lit_br4");
        lit_frame16(4'd15, 64, "lit_br15");

        // write exactly on the frame-boundary edge of the CLK_DIV=4 instance
        while (n % 16 != 15) idle(1);
        wr(2'd0, 16'h4321);
        idle(40);

        // reserved address
        wr(2'd3, 16'hFFFF);
        idle(40);

        // reset in the middle of digit 2 with a coincident write that must be dropped
        wr(2'd2, 16'h0003);
        idle(40);
        while (n % 16 != 9) idle(1);
        tick(1'b1, 1'b1, 2'd0, 16'hBEEF);
        idle(40);

        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            logic        r, we;
            logic [1:0]  a;
            logic [15:0] d;
            r  = ($urandom_range(0, 399) == 0);
            we = ($urandom_range(0, 5) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            tick(r, we, a, d);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Memory-mapped controller for the Basys3 4-digit seven-segment display. The CPU writes a value register, a digit-enable/decimal-point register and a brightness register. The block time-multiplexes the four digits itself and applies PWM dimming. New register contents are transferred to the display only at frame boundaries, so a value never tears mid-scan. It sits on the OTTER MMIO bus and drives the board ANODES/CATHODES pins directly.

Parameters:
CLK_DIV, 100000, CLK cycles per digit slot (1 ms at 100 MHz; 250 Hz frame rate); legal range 2..2^20
PWM_BITS, 4, width of brightness register and PWM phase counter

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
WR_EN  in  1  register write strobe, single-cycle
WR_ADDR  in  2  0=VALUE, 1=MASK, 2=BRIGHT, 3=reserved (write ignored)
WR_DATA  in  16  write data
CATHODES  out  8  {dp,a,b,c,d,e,f,g}, active-low
ANODES  out  4  {d4,d3,d2,d1}, active-low
FRAME_START  out  1  one-cycle pulse when digit 0 slot begins
DIGIT_IDX  out  2  digit currently scanned

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high; it is sampled only on the CLK rising edge.
- Reset values:
  - ANODES=4'hF, CATHODES=8'hFF, FRAME_START=0, DIGIT_IDX=0.
  - Shadow and active registers: VALUE=16'h0000, EN=4'hF, DP=4'h0, BRIGHT=all ones.
  - slot_cnt=0, pwm_cnt=0.
- Register writes (shadow set), applied on the edge after WR_EN:
  - addr0: VALUE<=WR_DATA.
  - addr1: EN<=WR_DATA[3:0], DP<=WR_DATA[7:4].
  - addr2: BRIGHT<=WR_DATA[PWM_BITS-1:0].
  - addr3: no effect.
  - Back-to-back writes are legal; the last write before the frame boundary wins.
- slot_cnt counts 0..CLK_DIV-1 and wraps. At terminal count, DIGIT_IDX increments mod 4.
- Frame boundary is terminal count while DIGIT_IDX==3. On that edge:
  - active set <= shadow set;
  - DIGIT_IDX <= 0;
  - FRAME_START asserts for exactly the next cycle.
- The first frame after reset is also a frame start: FRAME_START=1 in the first cycle after RST deasserts, using the reset values.
- A write coinciding with the frame-boundary edge lands in the shadow set only and appears one frame later.
- pwm_cnt is a free-running PWM_BITS counter; it increments every CLK and is not reset at slot boundaries.
- lit = active EN[DIGIT_IDX] AND (BRIGHT==all ones OR pwm_cnt < BRIGHT). BRIGHT=0 blanks everything; all ones gives a 100% duty cycle.
- Outputs are registered, one cycle after the internal state:
  - ANODES = lit ? one-hot-low(DIGIT_IDX) : 4'hF.
  - CATHODES = lit ? {~DP[DIGIT_IDX], seg(nibble)} : 8'hFF, where nibble = active VALUE[4*DIGIT_IDX +: 4].
  - seg encoding: 0=7'b0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- No X ever reaches the outputs. An undefined DIGIT_IDX decode drives ANODES=4'hF and CATHODES=8'hFF.
- RST asserted mid-scan: all state returns to reset values on that edge. Shadow writes in the same cycle are discarded.

Decomposition:
- Package sseg_pkg: 7-bit segment constant table indexed by nibble, ANODE_OFF/CATH_OFF constants, register address enum (ADDR_VALUE, ADDR_MASK, ADDR_BRIGHT).
- Sub-module sseg_decode: combinational nibble -> 7-bit segments, replacing the per-digit case blocks.

Test Plan:
- Reset hold, CLK_DIV=4 -> ANODES=F and CATHODES=FF during reset; after release, slot 0 shows VALUE=0: ANODES=1110, CATHODES=10000001; FRAME_START pulses once.
- Write VALUE=16'h1A3F mid-frame -> display stays 0000 until the next FRAME_START. Then slots give ANODES 1110/1101/1011/0111 with CATHODES for F,3,A,1 = 10111000, 10000110, 10001000, 11001111, each held 4 cycles.
- MASK write 16'h0035 (EN=0101, DP=0011) -> digits 1 and 3 stay blank (ANODES=F during their slots); digit 0 shows with dp=0; digit 2 shows with dp=1.
- BRIGHT: 0 -> ANODES=F for a full frame; 4 -> lit exactly 4 of every 16 cycles per digit (CLK_DIV=16); 15 -> lit continuously.
- Write on the exact frame-boundary edge -> new value is not shown next frame and appears the frame after; write to addr3 -> no visible change.
- Assert RST mid-slot 2 -> next cycle outputs off, DIGIT_IDX=0, shadow VALUE=0, BRIGHT=all ones.
